// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Issues sequential word-aligned fetches over a valid/ready channel and accepts
// in-order responses into a small FIFO. Decode sees one registered instruction
// per cycle. A redirect flushes the FIFO and discards responses still in flight.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic [31:0] ins_fetch_out,
   output logic [31:0] pc_out,
   output logic        ins_valid
);

   localparam int             CW      = $clog2(BUF_DEPTH) + 1;
   localparam int             PW      = $clog2(BUF_DEPTH);
   localparam logic [CW-1:0]  DEPTH_C = CW'(BUF_DEPTH);
   localparam logic [31:0]    NOP     = 32'h0000_0013;

   // Architectural state
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   ins_q, ins_d;
   logic [31:0]   pc_out_q, pc_out_d;
   logic          vld_q, vld_d;

   // Buffer storage: instruction word and its PC
   logic [31:0]   buf_ins_q [BUF_DEPTH];
   logic [31:0]   buf_pc_q  [BUF_DEPTH];

   logic [CW-1:0] credits;
   logic          req_fire;
   logic          resp_drop;
   logic          push;
   logic          pop;
   logic          unused_redirect_lsbs;

   // Low address bits of the redirect target are forced to zero.
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Credits reserve a buffer slot for every request already in flight, so a
   // response can always be pushed.
   assign credits        = DEPTH_C - count_q - outstanding_q;
   assign imem_req_valid = rst & ~redirect_valid & (credits != '0);
   assign imem_addr      = pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;

   assign resp_drop = imem_resp_valid & (discard_q != '0);
   assign push      = imem_resp_valid & ~redirect_valid & (discard_q == '0);
   assign pop       = ~redirect_valid & ~stall & (count_q != '0);

   assign ins_fetch_out = ins_q;
   assign pc_out        = pc_out_q;
   assign ins_valid     = vld_q;

   // Next-state computation; redirect overrides stall, push and issue.
   always_comb begin
      pc_d          = pc_q;
      resp_pc_d     = resp_pc_q;
      count_d       = count_q;
      discard_d     = discard_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      ins_d         = ins_q;
      pc_out_d      = pc_out_q;
      vld_d         = vld_q;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);

      if (redirect_valid) begin
         pc_d      = {redirect_pc[31:2], 2'b00};
         resp_pc_d = {redirect_pc[31:2], 2'b00};
         count_d   = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         // Everything still in flight is stale; a response arriving now is
         // dropped directly rather than counted.
         discard_d = outstanding_q - CW'(imem_resp_valid);
         ins_d     = NOP;
         vld_d     = 1'b0;
      end else begin
         if (req_fire) begin
            pc_d = pc_q + 32'd4;
         end
         if (resp_drop) begin
            discard_d = discard_q - CW'(1);
         end
         if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + PW'(1);
         end
         // Output register reads the head before this edge's push: no bypass.
         if (pop) begin
            ins_d    = buf_ins_q[rd_ptr_q];
            pc_out_d = buf_pc_q[rd_ptr_q];
            vld_d    = 1'b1;
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else if (!stall) begin
            ins_d = NOP;
            vld_d = 1'b0;
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q          <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         ins_q         <= NOP;
         pc_out_q      <= 32'h0;
         vld_q         <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         resp_pc_q     <= resp_pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         ins_q         <= ins_d;
         pc_out_q      <= pc_out_d;
         vld_q         <= vld_d;
      end
   end

   // Buffer write port; storage needs no reset since occupancy gates reads.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_ins_q[wr_ptr_q] <= imem_resp_data;
         buf_pc_q[wr_ptr_q]  <= resp_pc_q;
      end
   end

`ifndef SYNTHESIS
   // A push into a full buffer means the credit accounting is broken.
   always @(posedge clk) begin
      if (rst) begin
         assert (!(push && (count_q == DEPTH_C)))
            else $error("fetch_unit: push into full instruction buffer");
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: behavioural memory plus a queue-based model of
// in-flight requests and buffered words, driven by directed and random steps.
module tb_fetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] KEY      = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        stall = 1'b0;
   logic [31:0] ins_fetch_out;
   logic [31:0] pc_out;
   logic        ins_valid;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_addr       (imem_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .stall           (stall),
      .ins_fetch_out   (ins_fetch_out),
      .pc_out          (pc_out),
      .ins_valid       (ins_valid)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   req_t        pend[$];   // requests accepted by memory, not yet answered
   ent_t        buff[$];   // words fetched, not yet handed to decode
   logic [31:0] m_pc;
   logic [31:0] exp_ins;
   logic [31:0] exp_pc;
   logic        exp_vld;

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int lat       = 1;
   int resp_prob = 100;
   bit rand_lat  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
   endtask

   task automatic model_reset();
      pend.delete();
      buff.delete();
      m_pc    = RESET_PC;
      exp_ins = NOP;
      exp_pc  = 32'h0;
      exp_vld = 1'b0;
   endtask

   task automatic check_outputs(input string phase);
      chk({phase, ".ins_fetch_out"}, ins_fetch_out, exp_ins);
      chk({phase, ".pc_out"}, pc_out, exp_pc);
      chk({phase, ".ins_valid"}, {31'h0, ins_valid}, {31'h0, exp_vld});
   endtask

   // One clock cycle: drive inputs after the falling edge, check the request
   // side, advance the model across the rising edge, then check the outputs.
   task automatic step(input bit st, input bit rdy, input bit rd, input logic [31:0] rpc);
      bit          rv;
      bit          exp_rv;
      bit          acc;
      logic [31:0] rdata;
      int          l;
      req_t        e;
      ent_t        ent;

      rv    = 1'b0;
      rdata = 32'h0;
      if (pend.size() > 0 && pend[0].due <= cyc + 1 && $urandom_range(0, 99) < resp_prob) begin
         rv    = 1'b1;
         rdata = pend[0].addr ^ KEY;
      end
      stall           = st;
      imem_req_ready  = rdy;
      redirect_valid  = rd;
      redirect_pc     = rpc;
      imem_resp_valid = rv;
      imem_resp_data  = rv ? rdata : $urandom;
      #1;

      exp_rv = !rd && ((pend.size() + buff.size()) < DEPTH);
      chk("req_valid", {31'h0, imem_req_valid}, {31'h0, exp_rv});
      if (exp_rv) chk("req_addr", imem_addr, m_pc);
      acc = exp_rv && rdy;

      if (rd) begin
         if (rv) void'(pend.pop_front());
         foreach (pend[i]) pend[i].stale = 1'b1;
         buff.delete();
         m_pc    = rpc & ~32'h3;
         exp_ins = NOP;
         exp_vld = 1'b0;
      end else begin
         if (!st) begin
            if (buff.size() > 0) begin
               ent     = buff.pop_front();
               exp_ins = ent.ins;
               exp_pc  = ent.pc;
               exp_vld = 1'b1;
            end else begin
               exp_ins = NOP;
               exp_vld = 1'b0;
            end
         end
         if (rv) begin
            e = pend.pop_front();
            if (!e.stale) buff.push_back('{e.addr, e.addr ^ KEY});
         end
         if (acc) begin
            l = rand_lat ? int'($urandom_range(1, 3)) : lat;
            pend.push_back('{m_pc, cyc + 1 + l, 1'b0});
            m_pc = m_pc + 32'd4;
         end
      end

      @(posedge clk);
      cyc++;
      #1;
      check_outputs("out");
      @(negedge clk);
   endtask

   initial begin
      bit found;

      // Asynchronous reset with the clock low: outputs must clear at once.
      model_reset();
      #1 rst = 1'b0;
      #1;
      chk("reset.ins_fetch_out", ins_fetch_out, NOP);
      chk("reset.pc_out", pc_out, 32'h0);
      chk("reset.ins_valid", {31'h0, ins_valid}, 32'h0);
      chk("reset.req_valid", {31'h0, imem_req_valid}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Streaming with a single-cycle memory.
      lat = 1;
      repeat (20) step(1'b0, 1'b1, 1'b0, 32'h0);

      // Decode stall for four cycles, then resume.
      repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
      repeat (8) step(1'b0, 1'b1, 1'b0, 32'h0);

      // Memory back-pressure: address must hold while not accepted.
      repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
      repeat (8) step(1'b0, 1'b1, 1'b0, 32'h0);

      // Three-cycle memory; redirect once two fetches are in flight.
      lat   = 3;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (pend.size() == 2) found = 1'b1;
         else step(1'b0, 1'b1, 1'b0, 32'h0);
      end
      chk("two_outstanding_reached", {31'h0, found}, 32'h1);
      step(1'b0, 1'b1, 1'b1, 32'h0000_0103);
      chk("redirect.next_addr", imem_addr, 32'h0000_0100);
      repeat (15) step(1'b0, 1'b1, 1'b0, 32'h0);

      // Redirect, stall and a response on the same edge.
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (pend.size() > 0 && pend[0].due <= cyc + 1) found = 1'b1;
         else step(1'b0, 1'b1, 1'b0, 32'h0);
      end
      chk("resp_due_reached", {31'h0, found}, 32'h1);
      step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
      repeat (12) step(1'b0, 1'b1, 1'b0, 32'h0);

      // Randomised traffic: latency, gaps, stalls, back-pressure, redirects.
      rand_lat  = 1'b1;
      resp_prob = 70;
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 24) == 0, $urandom);
      end

      // Reset asserted between edges mid-stream.
      #2 rst = 1'b0;
      imem_resp_valid = 1'b0;
      redirect_valid  = 1'b0;
      stall           = 1'b0;
      #1;
      chk("midreset.ins_fetch_out", ins_fetch_out, NOP);
      chk("midreset.pc_out", pc_out, 32'h0);
      chk("midreset.ins_valid", {31'h0, ins_valid}, 32'h0);
      chk("midreset.req_valid", {31'h0, imem_req_valid}, 32'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      rand_lat  = 1'b0;
      lat       = 1;
      resp_prob = 100;
      chk("midreset.first_addr", imem_addr, RESET_PC);
      repeat (12) step(1'b0, 1'b1, 1'b0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
